// File: rtl/ultrasonic_echo_ranger.sv
// ultrasonic_echo_ranger: dual-channel HC-SR04 style range front end. Fires a
// trigger pulse on the left and right sensors in turn and measures each echo
// pulse width in clk cycles.
//
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   en                       ranging enable; low aborts to IDLE
//   echo_left, echo_right    sensor echo inputs (asynchronous to clk)
//   trig_left, trig_right    registered trigger outputs
//   left_time, right_time    last published echo width; 20'hFFFFF = no echo
//   valid_left, valid_right  one-cycle pulse when the matching time updates
//
// Optional feature: define ECHO_AVG_EN to publish the mean of the previous
// and current raw result per channel instead of the raw result.
module ultrasonic_echo_ranger #(
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int HOLDOFF_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        echo_left,
  input  logic        echo_right,
  output logic        trig_left,
  output logic        trig_right,
  output logic [19:0] left_time,
  output logic [19:0] right_time,
  output logic        valid_left,
  output logic        valid_right
);

  localparam logic [19:0] NO_ECHO      = 20'hFFFFF;
  localparam logic [31:0] TRIG_LAST    = 32'(TRIG_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] HOLD_LAST    = 32'(HOLDOFF_CYCLES - 1);
  localparam logic        CH_LEFT      = 1'b0;
  localparam logic        CH_RIGHT     = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  state_t      state, state_n;
  logic [31:0] tcnt, tcnt_n;   // phase timer for TRIG / WAIT_RISE / HOLDOFF
  logic [31:0] cnt, cnt_n;     // echo width counter
  logic        ch, ch_n;       // active channel
  logic        res_wr;         // result write, coincides with HOLDOFF entry
  logic [19:0] res_raw;        // raw result being written
  logic [19:0] pub;            // value published on res_wr

  // Two-flop synchronizers; both run continuously so switching channel never
  // exposes a stale half-synchronized sample.
  logic [1:0] sync_left, sync_right;
  logic       echo_s_left, echo_s_right, echo_act;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_left  <= 2'b00;
      sync_right <= 2'b00;
    end else begin
      sync_left  <= {sync_left[0], echo_left};
      sync_right <= {sync_right[0], echo_right};
    end
  end

  assign echo_s_left  = sync_left[1];
  assign echo_s_right = sync_right[1];
  assign echo_act     = (ch == CH_LEFT) ? echo_s_left : echo_s_right;

  // Saturate the 32-bit width count into the 20-bit result field.
  function automatic logic [19:0] sat20(input logic [31:0] v);
    if (v >= 32'(NO_ECHO)) sat20 = NO_ECHO;
    else                   sat20 = v[19:0];
  endfunction

  // Next-state logic.
  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    cnt_n   = cnt;
    ch_n    = ch;
    res_wr  = 1'b0;
    res_raw = NO_ECHO;

    case (state)
      IDLE: begin
        if (en) begin
          state_n = TRIG;
          tcnt_n  = '0;
        end
      end

      TRIG: begin
        if (tcnt == TRIG_LAST) begin
          state_n = WAIT_RISE;
          tcnt_n  = '0;
        end else begin
          tcnt_n = tcnt + 32'd1;
        end
      end

      WAIT_RISE: begin
        // An echo already high here is taken as the rise.
        if (echo_act) begin
          state_n = MEASURE;
          cnt_n   = 32'd1;
        end else if (tcnt == TIMEOUT_LAST) begin
          state_n = HOLDOFF;
          tcnt_n  = '0;
          res_wr  = 1'b1;
          res_raw = NO_ECHO;
        end else begin
          tcnt_n = tcnt + 32'd1;
        end
      end

      MEASURE: begin
        if (!echo_act) begin
          state_n = HOLDOFF;
          tcnt_n  = '0;
          res_wr  = 1'b1;
          res_raw = sat20(cnt);
        end else if (cnt >= TIMEOUT_LAST) begin
          // This high cycle would bring cnt to TIMEOUT_CYCLES: give up and
          // ignore the rest of the echo.
          state_n = HOLDOFF;
          tcnt_n  = '0;
          res_wr  = 1'b1;
          res_raw = NO_ECHO;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end

      HOLDOFF: begin
        if (tcnt == HOLD_LAST) begin
          ch_n    = ~ch;
          state_n = TRIG;
          tcnt_n  = '0;
        end else begin
          tcnt_n = tcnt + 32'd1;
        end
      end

      default: state_n = IDLE;
    endcase

    // Disable overrides everything: abandon the measurement, keep channel.
    if (!en) begin
      state_n = IDLE;
      tcnt_n  = '0;
      cnt_n   = '0;
      ch_n    = ch;
      res_wr  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      tcnt  <= '0;
      cnt   <= '0;
      ch    <= CH_LEFT;
    end else begin
      state <= state_n;
      tcnt  <= tcnt_n;
      cnt   <= cnt_n;
      ch    <= ch_n;
    end
  end

`ifdef ECHO_AVG_EN
  logic [19:0] prev_left, prev_right, prev_sel;

  assign prev_sel = (ch == CH_LEFT) ? prev_left : prev_right;

  // A missing echo on either side poisons the average so "clear" is never
  // reported as a half-way distance.
  always_comb begin
    if ((prev_sel == NO_ECHO) || (res_raw == NO_ECHO)) begin
      pub = NO_ECHO;
    end else begin
      pub = 20'(({1'b0, prev_sel} + {1'b0, res_raw}) >> 1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_left  <= NO_ECHO;
      prev_right <= NO_ECHO;
    end else if (res_wr) begin
      if (ch == CH_LEFT) prev_left  <= res_raw;
      else               prev_right <= res_raw;
    end
  end
`else
  assign pub = res_raw;
`endif

  // Registered outputs. Triggers follow the current state, so they rise one
  // edge after TRIG is entered and drop on the edge after en falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_left   <= 1'b0;
      trig_right  <= 1'b0;
      valid_left  <= 1'b0;
      valid_right <= 1'b0;
      left_time   <= NO_ECHO;
      right_time  <= NO_ECHO;
    end else begin
      trig_left   <= en && (state == TRIG) && (ch == CH_LEFT);
      trig_right  <= en && (state == TRIG) && (ch == CH_RIGHT);
      valid_left  <= res_wr && (ch == CH_LEFT);
      valid_right <= res_wr && (ch == CH_RIGHT);
      if (res_wr && (ch == CH_LEFT))  left_time  <= pub;
      if (res_wr && (ch == CH_RIGHT)) right_time <= pub;
    end
  end

endmodule
